bcd_countdown_timer: RTL and testbench

- Programmable multi-digit BCD down-counter; the counting-down counterpart of the 1 kHz→1 Hz cascaded BCD up-counter divider.
- Loads a BCD preset and decrements once per qualified `tick`. `tick` is typically the divider's one-cycle OneHertz pulse.
- Exposes per-digit borrow enables, mirroring the divider's carry enables.
- Signals expiry with a one-cycle pulse and a sticky state. Sits between the timebase divider and the display/alarm logic.

---
 rtl/bcd_countdown_timer_pkg.sv | 18 +
 rtl/bcd_countdown_timer_digit.sv | 33 +++
 rtl/bcd_countdown_timer.sv | 114 +++++++++++
 tb/tb_bcd_countdown_timer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_countdown_timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
package bcd_countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] nib);
    return (nib > BCD_MAX) ? BCD_MAX : nib;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_digit.sv
// One BCD down-counting digit: clamps on load, wraps 0 -> 9 when enabled.
module bcd_down_digit
  import bcd_countdown_timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       enable,
  output logic [3:0] digit,
  output logic       is_zero
);

  logic [3:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = bcd_clamp(load_digit);
    end else if (enable) begin
      digit_d = (digit_q == BCD_ZERO) ? BCD_MAX : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) digit_q <= BCD_ZERO;
    else        digit_q <= digit_d;
  end

  assign digit   = digit_q;
  assign is_zero = (digit_q == BCD_ZERO);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer: run/pause/expire FSM over a chain of down digits.
module bcd_countdown_timer
  import bcd_countdown_timer_pkg::*;
#(
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  start,
  input  logic                  pause,
  output logic [4*DIGITS-1:0]   count,
  output logic [DIGITS-1:0]     b_enable,
  output logic                  running,
  output logic                  expired,
  output logic                  done
);

  state_e state_q;
  logic   running_q, done_q, expired_q;

  logic [3:0]        digit_w [DIGITS];
  logic [DIGITS-1:0] is_zero_w;
  logic [DIGITS-1:0] b_en_w;
  logic              all_zero, count_is_one, dec_en;

  always_comb begin
    logic chain;
    logic upper_zero;
    chain      = 1'b1;
    upper_zero = 1'b1;
    b_en_w     = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      b_en_w[i] = chain;
      chain     = chain & is_zero_w[i];
      if (i > 0) upper_zero = upper_zero & is_zero_w[i];
    end
    all_zero     = chain;
    count_is_one = upper_zero && (digit_w[0] == 4'd1);
  end

  // all_zero guard keeps the chain from ever wrapping 000 -> 999
  assign dec_en = (state_q == ST_RUN) && tick && !load && !pause && !all_zero;

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
    bcd_down_digit u_digit (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .load_digit (load_value[4*g +: 4]),
      .enable     (dec_en & b_en_w[g]),
      .digit      (digit_w[g]),
      .is_zero    (is_zero_w[g])
    );
    assign count[4*g +: 4] = digit_w[g];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      expired_q <= 1'b0;
      if (load) begin
        state_q   <= ST_IDLE;
        running_q <= 1'b0;
        done_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              if (all_zero) begin
                state_q   <= ST_EXPIRED;
                done_q    <= 1'b1;
                expired_q <= 1'b1;
              end else begin
                state_q   <= ST_RUN;
                running_q <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (pause) begin
              state_q   <= ST_PAUSED;
              running_q <= 1'b0;
            end else if (tick && count_is_one) begin
              state_q   <= ST_EXPIRED;
              running_q <= 1'b0;
              done_q    <= 1'b1;
              expired_q <= 1'b1;
            end
          end
          ST_PAUSED: begin
            if (start && !pause) begin
              state_q   <= ST_RUN;
              running_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign b_enable = b_en_w;
  assign running  = running_q;
  assign done     = done_q;
  assign expired  = expired_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench: a decimal reference model predicts each cycle's outputs.
module tb_bcd_countdown_timer;

  localparam int D = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          tick, load, start, pause;
  logic [4*D-1:0] load_value;
  logic [4*D-1:0] count;
  logic [D-1:0]   b_enable;
  logic          running, expired, done;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [11:0] cnt;
    logic [2:0]  be;
    logic        run;
    logic        dn;
    logic        ex;
  } exp_t;

  exp_t sb_q[$];

  // model: 0 idle, 1 run, 2 paused, 3 expired
  int m_val;
  int m_st;

  bcd_countdown_timer #(.DIGITS(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .pause      (pause),
    .count      (count),
    .b_enable   (b_enable),
    .running    (running),
    .expired    (expired),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    int t;
    t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int clamp_val(input logic [11:0] lv);
    int v, m, n;
    v = 0;
    m = 1;
    for (int i = 0; i < D; i++) begin
      n = int'(lv[4*i +: 4]);
      if (n > 9) n = 9;
      v += n * m;
      m *= 10;
    end
    return v;
  endfunction

  // one clock: drive at negedge, predict, sample 1 ns after the rising edge
  task automatic step(input bit ld, input logic [11:0] lv, input bit st,
                      input bit ps, input bit tk, input string tag);
    exp_t e, got;
    bit   ex;
    @(negedge clk);
    load = ld; load_value = lv; start = st; pause = ps; tick = tk;
    ex = 1'b0;
    if (ld) begin
      m_val = clamp_val(lv);
      m_st  = 0;
    end else begin
      case (m_st)
        0: if (st) begin
             if (m_val == 0) begin m_st = 3; ex = 1'b1; end
             else m_st = 1;
           end
        1: if (ps) m_st = 2;
           else if (tk) begin
             m_val = m_val - 1;
             if (m_val == 0) begin m_st = 3; ex = 1'b1; end
           end
        2: if (st && !ps) m_st = 1;
        default: ;
      endcase
    end
    e.cnt = to_bcd(m_val);
    e.be  = {(m_val % 100) == 0, (m_val % 10) == 0, 1'b1};
    e.run = (m_st == 1);
    e.dn  = (m_st == 3);
    e.ex  = ex;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_val({tag, "/sb_empty"}, 32'd0, 32'd1);
    end else begin
      got = sb_q.pop_front();
      check_val({tag, "/count"},    32'(count),    32'(got.cnt));
      check_val({tag, "/b_enable"}, 32'(b_enable), 32'(got.be));
      check_val({tag, "/running"},  32'(running),  32'(got.run));
      check_val({tag, "/done"},     32'(done),     32'(got.dn));
      check_val({tag, "/expired"},  32'(expired),  32'(got.ex));
    end
  endtask

  task automatic idle_step(input string tag);
    step(0, 12'h000, 0, 0, 0, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    tick = 0; load = 0; start = 0; pause = 0; load_value = '0;
    m_val = 0; m_st = 0;

    // reset held: stimulus must have no effect
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tick = i[0]; start = ~i[0];
      @(posedge clk); #1;
      check_val("rst/count",   32'(count),   32'd0);
      check_val("rst/running", 32'(running), 32'd0);
      check_val("rst/done",    32'(done),    32'd0);
      check_val("rst/expired", 32'(expired), 32'd0);
    end
    @(negedge clk);
    tick = 0; start = 0;
    reset = 1'b1;
    idle_step("post_rst0");
    idle_step("post_rst1");

    // 100 -> 099 borrows through all digits
    step(1, 12'h100, 0, 0, 0, "t1_load");
    step(0, 12'h000, 1, 0, 0, "t1_start");
    step(0, 12'h000, 0, 0, 1, "t1_tick");

    // 002 -> 001 -> 000, expire, hold at zero
    step(1, 12'h002, 0, 0, 0, "t2_load");
    step(0, 12'h000, 1, 0, 0, "t2_start");
    step(0, 12'h000, 0, 0, 1, "t2_tick1");
    step(0, 12'h000, 0, 0, 1, "t2_tick2");
    idle_step("t2_after");
    step(0, 12'h000, 0, 0, 1, "t2_tick3");
    step(0, 12'h000, 1, 1, 1, "t2_ignored");

    // pause wins over a same-cycle tick, start resumes
    step(1, 12'h050, 0, 0, 0, "t3_load");
    step(0, 12'h000, 1, 0, 0, "t3_start");
    step(0, 12'h000, 0, 0, 1, "t3_tick");
    step(0, 12'h000, 0, 1, 1, "t3_pause");
    step(0, 12'h000, 0, 0, 1, "t3_ptick");
    step(0, 12'h000, 1, 0, 0, "t3_resume");
    step(0, 12'h000, 0, 0, 1, "t3_tick2");

    // load during RUN with tick, clamp of 0xA nibble
    step(1, 12'h037, 0, 0, 0, "t4_load");
    step(0, 12'h000, 1, 0, 0, "t4_start");
    step(1, 12'hA25, 0, 0, 1, "t4_reload");
    step(0, 12'h000, 0, 0, 1, "t4_idle_tick");

    // start at zero expires immediately; load leaves EXPIRED
    step(1, 12'h000, 0, 0, 0, "t5_load0");
    step(0, 12'h000, 1, 0, 0, "t5_start");
    idle_step("t5_hold");
    step(1, 12'h005, 0, 0, 0, "t5_load5");

    // random mix, small presets so expiry is reached often
    for (int i = 0; i < 150; i++) begin
      bit ld, st, ps, tk;
      logic [11:0] lv;
      ld = ($urandom_range(0, 15) == 0);
      st = ($urandom_range(0, 3) == 0);
      ps = ($urandom_range(0, 9) == 0);
      tk = ($urandom_range(0, 1) == 1);
      lv = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      step(ld, lv, st, ps, tk, "rand");
    end

    // asynchronous reset mid-RUN
    step(1, 12'h050, 0, 0, 0, "t7_load");
    step(0, 12'h000, 1, 0, 0, "t7_start");
    step(0, 12'h000, 0, 0, 1, "t7_tick");
    @(negedge clk);
    tick = 0; start = 0; load = 0; pause = 0;
    #2 reset = 1'b0;
    #1;
    check_val("t7_async/count",   32'(count),   32'd0);
    check_val("t7_async/running", 32'(running), 32'd0);
    m_val = 0; m_st = 0;
    @(negedge clk);
    reset = 1'b1;
    step(0, 12'h000, 0, 0, 1, "t7_post_tick");
    step(0, 12'h000, 0, 0, 1, "t7_post_tick2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
